// File: rtl/mem_responder.sv
// Main-memory slave model: line-organised storage that accepts tagged line reads and
// single-beat byte-masked writes, one request outstanding, with programmable read latency.
module mem_responder #(
    parameter int ADDR_BITS    = 28,
    parameter int DATA_BITS    = 128,
    parameter int TAG_BITS     = 5,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic                   mem_req_rw,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic [TAG_BITS-1:0]    mem_req_tag,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic [1:0]             mem_req_data_offset,
    output logic                   mem_resp_valid,
    output logic [DATA_BITS-1:0]   mem_resp_data,
    output logic [TAG_BITS-1:0]    mem_resp_tag
);

    localparam int BEAT_BYTES = DATA_BITS / 8;
    localparam int ENTRIES    = (1 << DEPTH_LOG2) * 4;
    localparam int CNT_BITS   = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
    // One latency cycle is spent on the handshake edge and one on the edge that raises valid.
    localparam int LAT_LOAD   = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RLAT  = 2'd2,
        ST_RRESP = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    idle_r;
    logic                    data_ready_r;
    logic                    resp_valid_r;
    logic [DATA_BITS-1:0]    resp_data_r;
    logic [TAG_BITS-1:0]     resp_tag_r;
    logic [DEPTH_LOG2-1:0]   line_r;
    logic [TAG_BITS-1:0]     tag_r;
    logic [CNT_BITS-1:0]     cnt_r;
    logic [1:0]              beat_r;

    logic [DATA_BITS-1:0]    mem_r [ENTRIES];

    logic                    req_fire_s;
    logic                    data_fire_s;
    logic [DEPTH_LOG2-1:0]   rd_line_s;
    logic [1:0]              rd_beat_s;
    logic [DATA_BITS-1:0]    rd_word_s;
    logic [DEPTH_LOG2+1:0]   wr_idx_s;
    logic                    unused_addr_s;

    assign req_fire_s    = mem_req_valid & idle_r;
    assign data_fire_s   = mem_req_data_valid & data_ready_r;
    assign wr_idx_s      = {line_r, mem_req_data_offset};
    assign rd_word_s     = mem_r[{rd_line_s, rd_beat_s}];
    assign unused_addr_s = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    // Ready is masked by reset so it is low for the whole reset pulse and high right after.
    assign mem_req_ready      = idle_r & ~reset;
    assign mem_req_data_ready = data_ready_r;
    assign mem_resp_valid     = resp_valid_r;
    assign mem_resp_data      = resp_data_r;
    assign mem_resp_tag       = resp_tag_r;

    // Read-port address: the beat that the next response register load will capture.
    always_comb begin
        rd_line_s = line_r;
        rd_beat_s = 2'd0;
        if (state_r == ST_IDLE) begin
            rd_line_s = mem_req_addr[DEPTH_LOG2-1:0];
            rd_beat_s = 2'd0;
        end else if (state_r == ST_RRESP) begin
            rd_line_s = line_r;
            rd_beat_s = beat_r + 2'd1;
        end else begin
            rd_line_s = line_r;
            rd_beat_s = 2'd0;
        end
    end

    // Byte-enabled storage write; not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if ((state_r == ST_WDATA) && data_fire_s) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (mem_req_data_mask[i]) begin
                    mem_r[wr_idx_s][i*8 +: 8] <= mem_req_data_bits[i*8 +: 8];
                end
            end
        end
    end

    // Request/data/response sequencer with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            idle_r       <= 1'b1;
            data_ready_r <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= '0;
            resp_tag_r   <= '0;
            line_r       <= '0;
            tag_r        <= '0;
            cnt_r        <= '0;
            beat_r       <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_fire_s) begin
                        line_r <= mem_req_addr[DEPTH_LOG2-1:0];
                        idle_r <= 1'b0;
                        if (mem_req_rw) begin
                            data_ready_r <= 1'b1;
                            state_r      <= ST_WDATA;
                        end else begin
                            tag_r <= mem_req_tag;
                            if (READ_LATENCY == 1) begin
                                resp_valid_r <= 1'b1;
                                resp_data_r  <= rd_word_s;
                                resp_tag_r   <= mem_req_tag;
                                beat_r       <= 2'd0;
                                state_r      <= ST_RRESP;
                            end else begin
                                cnt_r   <= CNT_BITS'(LAT_LOAD);
                                state_r <= ST_RLAT;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (data_fire_s) begin
                        data_ready_r <= 1'b0;
                        idle_r       <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_RLAT: begin
                    if (cnt_r == '0) begin
                        resp_valid_r <= 1'b1;
                        resp_data_r  <= rd_word_s;
                        resp_tag_r   <= tag_r;
                        beat_r       <= 2'd0;
                        state_r      <= ST_RRESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_BITS'(1);
                    end
                end
                ST_RRESP: begin
                    if (beat_r == 2'd3) begin
                        resp_valid_r <= 1'b0;
                        resp_data_r  <= '0;
                        resp_tag_r   <= '0;
                        idle_r       <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        beat_r      <= beat_r + 2'd1;
                        resp_data_r <= rd_word_s;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    idle_r       <= 1'b1;
                    data_ready_r <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: each task drives one scenario and checks its
// outputs against hand-computed values.
module tb_mem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [4:0]   mem_req_tag;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic [1:0]   mem_req_data_offset;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [4:0]   mem_resp_tag;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] PAT   = 128'hC0DE0000_00000000_00000000_00000000;
    localparam logic [127:0] APAT  = 128'hA11A5000_00000000_00000000_00000000;
    localparam logic [127:0] EARLY = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;

    mem_responder #(
        .ADDR_BITS(28), .DATA_BITS(128), .TAG_BITS(5), .DEPTH_LOG2(10), .READ_LATENCY(4)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_req_data_offset(mem_req_data_offset),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_tag(mem_resp_tag)
    );

    always #5 clk = ~clk;

    // Issues one write request then its data beat; returns in the first cycle after the data edge.
    task automatic do_write(input logic [27:0] a, input logic [1:0] off,
                            input logic [127:0] d, input logic [15:0] m);
        mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = a;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        mem_req_data_valid = 1'b1; mem_req_data_bits = d;
        mem_req_data_mask = m; mem_req_data_offset = off;
        @(posedge clk); #1;
        mem_req_data_valid = 1'b0;
    endtask

    // Issues one read and collects 4 beats; lat counts cycles from handshake to beat 0.
    task automatic do_read(input logic [27:0] a, input logic [4:0] t,
                           output logic [3:0][127:0] beats, output logic [4:0] tg,
                           output int lat, output bit ok);
        ok = 1'b1; tg = 5'd0; beats = '0;
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = a; mem_req_tag = t;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        lat = 1;
        while (!mem_resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!mem_resp_valid) begin
            ok = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!mem_resp_valid) ok = 1'b0;
                beats[i] = mem_resp_data;
                if (i == 0) tg = mem_resp_tag;
                else if (mem_resp_tag !== tg) ok = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (mem_req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", mem_req_ready); end
        tests++; if (mem_req_data_ready !== 1'b0) begin fails++; $display("FAIL reset_data_ready got %b want 0", mem_req_data_ready); end
        tests++; if (mem_resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", mem_resp_valid); end
        tests++; if (mem_resp_data !== 128'd0 || mem_resp_tag !== 5'd0) begin fails++; $display("FAIL reset_resp_bits got %h/%h want 0/0", mem_resp_data, mem_resp_tag); end
        reset = 1'b0;
        #1;
        tests++; if (mem_req_ready !== 1'b1) begin fails++; $display("FAIL release_ready got %b want 1", mem_req_ready); end
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (mem_resp_valid !== 1'b0) seen = 1'b1; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL idle_no_resp got %b want 0", seen); end
    endtask

    task automatic test_full_line;
        logic [3:0][127:0] b; logic [4:0] tg; int lat; bit ok;
        for (int i = 0; i < 4; i++) do_write(28'h5, 2'(i), PAT | 128'(i), 16'hFFFF);
        do_read(28'h5, 5'd7, b, tg, lat, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL full_line_beats got ok=%b want 1", ok); end
        tests++; if (lat != 4) begin fails++; $display("FAIL full_line_latency got %0d want 4", lat); end
        tests++; if (tg !== 5'd7) begin fails++; $display("FAIL full_line_tag got %0d want 7", tg); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (b[i] !== (PAT | 128'(i))) begin fails++; $display("FAIL full_line_beat%0d got %h want %h", i, b[i], PAT | 128'(i)); end
        end
        tests++; if (mem_resp_valid !== 1'b0 || mem_req_ready !== 1'b1) begin fails++; $display("FAIL after_read got valid=%b ready=%b want 0/1", mem_resp_valid, mem_req_ready); end
    endtask

    task automatic test_partial_mask;
        logic [3:0][127:0] b; logic [4:0] tg; int lat; bit ok;
        for (int i = 0; i < 4; i++) do_write(28'h9, 2'(i), 128'd0, 16'hFFFF);
        do_write(28'h9, 2'd2, {8{16'hAAAA}}, 16'h0003);
        do_read(28'h9, 5'd2, b, tg, lat, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL partial_beats got ok=%b want 1", ok); end
        tests++; if (b[2] !== 128'h0000AAAA - 128'h0000AAAA + 128'hAAAA) begin fails++; $display("FAIL partial_beat2 got %h want %h", b[2], 128'hAAAA); end
        tests++; if (b[0] !== 128'd0 || b[1] !== 128'd0 || b[3] !== 128'd0) begin fails++; $display("FAIL partial_others got %h %h %h want 0", b[0], b[1], b[3]); end
    endtask

    task automatic test_early_data;
        logic [3:0][127:0] b; logic [4:0] tg; int lat; bit ok;
        mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = 28'hA;
        mem_req_data_valid = 1'b1; mem_req_data_bits = EARLY;
        mem_req_data_mask = 16'hFFFF; mem_req_data_offset = 2'd1;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        tests++; if (mem_req_data_ready !== 1'b1 || mem_req_ready !== 1'b0) begin fails++; $display("FAIL early_not_taken got dready=%b ready=%b want 1/0", mem_req_data_ready, mem_req_ready); end
        @(posedge clk); #1;
        mem_req_data_valid = 1'b0;
        tests++; if (mem_req_ready !== 1'b1 || mem_req_data_ready !== 1'b0) begin fails++; $display("FAIL early_taken got ready=%b dready=%b want 1/0", mem_req_ready, mem_req_data_ready); end
        do_read(28'hA, 5'd5, b, tg, lat, ok);
        tests++; if (ok !== 1'b1 || b[1] !== EARLY) begin fails++; $display("FAIL early_data got %h ok=%b want %h", b[1], ok, EARLY); end
    endtask

    task automatic test_mask_zero;
        logic [3:0][127:0] b; logic [4:0] tg; int lat; bit ok;
        do_write(28'h5, 2'd0, {128{1'b1}}, 16'h0000);
        tests++; if (mem_req_ready !== 1'b1) begin fails++; $display("FAIL mask0_ready got %b want 1", mem_req_ready); end
        do_read(28'h5, 5'd1, b, tg, lat, ok);
        tests++; if (ok !== 1'b1 || b[0] !== PAT || b[3] !== (PAT | 128'd3)) begin fails++; $display("FAIL mask0_unchanged got %h %h want %h %h", b[0], b[3], PAT, PAT | 128'd3); end
    endtask

    task automatic test_reset_mid_op;
        logic [3:0][127:0] b; logic [4:0] tg; int lat; bit ok; bit seen; int n;
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 28'h5; mem_req_tag = 5'd3;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        n = 0;
        while (!mem_resp_valid && n < 40) begin @(posedge clk); #1; n++; end
        tests++; if (mem_resp_valid !== 1'b1) begin fails++; $display("FAIL rst_read_beat0 got valid=%b want 1", mem_resp_valid); end
        @(posedge clk); #1;
        tests++; if (mem_resp_data !== (PAT | 128'd1) || mem_resp_tag !== 5'd3) begin fails++; $display("FAIL rst_read_beat1 got %h/%0d want %h/3", mem_resp_data, mem_resp_tag, PAT | 128'd1); end
        reset = 1'b1;
        #1;
        tests++; if (mem_resp_valid !== 1'b0 || mem_resp_data !== 128'd0 || mem_resp_tag !== 5'd0 || mem_req_ready !== 1'b0) begin fails++; $display("FAIL rst_drop got valid=%b data=%h tag=%0d ready=%b want 0", mem_resp_valid, mem_resp_data, mem_resp_tag, mem_req_ready); end
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (mem_resp_valid !== 1'b0) seen = 1'b1; end
        reset = 1'b0;
        #1;
        tests++; if (mem_req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b want 1", mem_req_ready); end
        repeat (6) begin @(posedge clk); #1; if (mem_resp_valid !== 1'b0) seen = 1'b1; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_no_more_beats got %b want 0", seen); end
        do_read(28'h5, 5'd9, b, tg, lat, ok);
        tests++; if (ok !== 1'b1 || tg !== 5'd9 || b[2] !== (PAT | 128'd2)) begin fails++; $display("FAIL rst_new_read got %h tag=%0d ok=%b want %h tag=9", b[2], tg, ok, PAT | 128'd2); end
        // A write whose data beat is pending when reset hits must leave the line alone.
        mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = 28'h5;
        @(posedge clk); #1;
        mem_req_valid = 1'b0; reset = 1'b1;
        mem_req_data_valid = 1'b1; mem_req_data_bits = {128{1'b1}};
        mem_req_data_mask = 16'hFFFF; mem_req_data_offset = 2'd2;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        mem_req_data_valid = 1'b0;
        do_read(28'h5, 5'd4, b, tg, lat, ok);
        tests++; if (ok !== 1'b1 || b[2] !== (PAT | 128'd2)) begin fails++; $display("FAIL rst_write_abort got %h want %h", b[2], PAT | 128'd2); end
    endtask

    task automatic test_alias;
        logic [3:0][127:0] b; logic [4:0] tg; int lat; bit ok;
        for (int i = 0; i < 4; i++) do_write(28'h3, 2'(i), APAT | 128'(i), 16'hFFFF);
        do_read(28'h403, 5'd4, b, tg, lat, ok);
        tests++; if (ok !== 1'b1 || tg !== 5'd4) begin fails++; $display("FAIL alias_read got ok=%b tag=%0d want 1/4", ok, tg); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (b[i] !== (APAT | 128'(i))) begin fails++; $display("FAIL alias_beat%0d got %h want %h", i, b[i], APAT | 128'(i)); end
        end
    endtask

    task automatic test_back_to_back;
        logic v [15]; logic r [15]; logic [127:0] d [15]; logic [4:0] t [15];
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 28'h5; mem_req_tag = 5'd1;
        @(posedge clk); #1;
        mem_req_addr = 28'h3; mem_req_tag = 5'd2;
        for (int k = 1; k < 15; k++) begin
            @(posedge clk); #1;
            v[k] = mem_resp_valid; r[k] = mem_req_ready; d[k] = mem_resp_data; t[k] = mem_resp_tag;
            if (k == 8) mem_req_valid = 1'b0;
        end
        for (int k = 3; k < 7; k++) begin
            tests++; if (v[k] !== 1'b1 || t[k] !== 5'd1 || d[k] !== (PAT | 128'(k - 3))) begin fails++; $display("FAIL b2b_first_beat%0d got v=%b tag=%0d data=%h want 1/1/%h", k - 3, v[k], t[k], d[k], PAT | 128'(k - 3)); end
        end
        tests++; if (r[7] !== 1'b1 || v[7] !== 1'b0) begin fails++; $display("FAIL b2b_ready_after_beat3 got ready=%b valid=%b want 1/0", r[7], v[7]); end
        tests++; if (r[8] !== 1'b0) begin fails++; $display("FAIL b2b_second_accept got ready=%b want 0", r[8]); end
        tests++; if (v[10] !== 1'b0 || v[11] !== 1'b1 || t[11] !== 5'd2 || d[11] !== APAT) begin fails++; $display("FAIL b2b_second_beat0 got v10=%b v11=%b tag=%0d data=%h want 0/1/2/%h", v[10], v[11], t[11], d[11], APAT); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (mem_req_ready !== 1'b1 || mem_resp_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got ready=%b valid=%b want 1/0", mem_req_ready, mem_resp_valid); end
    endtask

    initial begin
        reset = 1'b1;
        mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = 28'd0; mem_req_tag = 5'd0;
        mem_req_data_valid = 1'b0; mem_req_data_bits = 128'd0;
        mem_req_data_mask = 16'd0; mem_req_data_offset = 2'd0;
        test_reset();
        test_full_line();
        test_partial_mask();
        test_early_data();
        test_mask_zero();
        test_reset_mid_op();
        test_alias();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory slave model at the far end of the arbiter-to-memory interface: accepts tagged line-read and single-beat masked-write requests and returns tagged read data.
- Stands in for DRAM in simulation and on FPGA; owns a synthesizable line-organised storage array plus the request/data/response sequencing.
- Supports one outstanding request at a time; read latency is programmable.

Parameters:
- ADDR_BITS, 28: width of mem_req_addr; one address is one 512-bit line.
- DATA_BITS, 128: beat width; a line is 4 beats.
- TAG_BITS, 5: request/response tag width.
- DEPTH_LOG2, 10: number of lines stored is 2^DEPTH_LOG2; only mem_req_addr[DEPTH_LOG2-1:0] is used.
- READ_LATENCY, 4: number of cycles from the read handshake edge to the first response beat. Must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_req_valid  in  1  request valid
- mem_req_ready  out  1  request accepted when valid & ready at a rising edge
- mem_req_rw  in  1  1 = write, 0 = read
- mem_req_addr  in  ADDR_BITS  line address
- mem_req_tag  in  TAG_BITS  request tag
- mem_req_data_valid  in  1  write beat valid
- mem_req_data_ready  out  1  write beat accepted when valid & ready
- mem_req_data_bits  in  DATA_BITS  write data
- mem_req_data_mask  in  DATA_BITS/8  per-byte enable; bit i enables byte i
- mem_req_data_offset  in  2  beat index within the line for the write
- mem_resp_valid  out  1  read beat valid; there is no ready, so the consumer must always accept
- mem_resp_data  out  DATA_BITS  read beat
- mem_resp_tag  out  TAG_BITS  tag of the read request

Behaviour:
- Reset (asynchronous, active-high):
  - Return to IDLE.
  - mem_req_ready=0 while reset is asserted, then 1 in the first IDLE cycle.
  - mem_req_data_ready=0, mem_resp_valid=0, mem_resp_data=0, mem_resp_tag=0.
  - Counters are cleared. Storage contents are not cleared.
  - Reset mid-operation aborts any pending write (no array update) or any read (remaining beats are dropped).
- State machine:
  - IDLE: mem_req_ready=1. On a request handshake:
    - rw=1: latch addr and go to WDATA.
    - rw=0: latch addr and tag, load the latency counter with READ_LATENCY-1, and go to RLAT.
  - WDATA: mem_req_ready=0, mem_req_data_ready=1. On a data handshake, for each byte i with mask[i]=1, write byte i of line[addr][offset]; then go to IDLE.
    - A write never produces a response.
    - mask=0 completes the write with no array change.
  - RLAT: both readies low. Decrement the counter each cycle; when it reaches 0, go to RRESP with beat counter 0.
  - RRESP: mem_resp_valid=1, mem_resp_data=line[addr][beat], mem_resp_tag=latched tag. Beats 0,1,2,3 go out on 4 consecutive cycles; after beat 3, go to IDLE.
- Timing and latency:
  - A read handshake at edge E puts beat 0 valid in the cycle after edge E+READ_LATENCY-1. With READ_LATENCY=1, beat 0 appears in the cycle immediately after the handshake.
  - mem_req_ready rises in the cycle after the last read beat, or in the cycle after the write-data handshake.
- Ordering: a write data handshake at edge E is visible to any read accepted afterwards, which is guaranteed by the single-outstanding design.
- Early write data: mem_req_data_valid asserted in IDLE together with the write request is not accepted that cycle. It is taken in the first WDATA cycle if still valid. The sender must hold valid and data stable until ready.
- Stray data: mem_req_data_valid outside WDATA is ignored.
- Address aliasing: upper address bits above DEPTH_LOG2 are ignored, so addresses alias modulo 2^DEPTH_LOG2.
- Back-to-back requests: a request held valid continuously is re-accepted on the first IDLE cycle.
- Array: 2^DEPTH_LOG2 × 4 entries of DATA_BITS, with a byte-enabled write port and one read port. The read is combinational or registered internally, with the latency absorbed into RLAT so that the external timing above holds.

Test Plan:
- Reset then idle: assert reset for 3 cycles mid-simulation → all outputs 0 during reset; mem_req_ready=1 in the first cycle after release; mem_resp_valid never rises with no requests.
- Full-line write/read:
  - Stimulus: four writes to addr 0x5, offsets 0–3, mask 0xFFFF, data 0x...00 to 0x...03, then a read of addr 0x5 with tag 7 and READ_LATENCY=4.
  - Expected: 4 consecutive resp beats returning data 00,01,02,03, tag=7; beat 0 appears 4 cycles after the read handshake.
- Partial mask: write offset 2, mask 0x0003, data 0xAAAA...AAAA over a line of zeros, then read → beat 2 = 0x0000...AAAA; beats 0, 1 and 3 unchanged.
- Handshake corner cases:
  - Write request with data_valid in the same cycle → data accepted the next cycle, not the request cycle.
  - Write with mask=0 → array unchanged; ready returns the following cycle.
- Reset during read: assert reset after beat 1 of a read → mem_resp_valid drops immediately; no further beats; a new read afterwards returns correct data and tag.
- Aliasing and back-to-back:
  - Write addr 0x3 then read addr 0x403 with DEPTH_LOG2=10 → the same data is returned.
  - Two reads held valid continuously → the second is accepted in the cycle after the first read's beat 3.
